// File: rtl/anim_frame_sequencer.sv
// anim_frame_sequencer
//   Steps a frame index through an animation sequence. Each rising edge of
//   the divided clock (tick_clk) is one animation tick. TICKS_PER_FRAME ticks
//   make up one frame. Playback is controlled with start/stop/pause/loop_en.
//
//   Optional feature macro: ANIM_PINGPONG_EN
//     defined   : loop mode plays back and forth (0..N-1..0..). Play-once
//                 mode stays forward-only.
//     undefined : loop mode wraps from NUM_FRAMES-1 to 0.
//
// Ports
//   I_CLK      in   system clock
//   rst        in   synchronous, active-high reset
//   tick_clk   in   divided clock. It is a register in the I_CLK domain.
//   start      in   pulse: (re)start the sequence at frame 0
//   stop       in   pulse: abort and return to idle
//   pause      in   level: freeze the sequence while high
//   loop_en    in   level: 1 = repeat, 0 = play once
//   frame_idx  out  current frame index
//   frame_stb  out  one-cycle pulse when a new frame is presented
//   busy       out  high while playing or paused
//   done       out  one-cycle pulse when a play-once sequence completes
module anim_frame_sequencer #(
    parameter int NUM_FRAMES      = 48,
    parameter int FRAME_W         = 6,
    parameter int TICKS_PER_FRAME = 5,
    parameter int TPF_W           = 8
) (
    input  logic               I_CLK,
    input  logic               rst,
    input  logic               tick_clk,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic               loop_en,
    output logic [FRAME_W-1:0] frame_idx,
    output logic               frame_stb,
    output logic               busy,
    output logic               done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(NUM_FRAMES - 1);
    localparam logic [TPF_W-1:0]   LAST_TICK  = TPF_W'(TICKS_PER_FRAME - 1);

`ifdef ANIM_PINGPONG_EN
    // Turn-around targets. For a single-frame sequence both collapse to 0.
    localparam logic [FRAME_W-1:0] TURN_DOWN = FRAME_W'((NUM_FRAMES > 1) ? NUM_FRAMES - 2 : 0);
    localparam logic [FRAME_W-1:0] TURN_UP   = FRAME_W'((NUM_FRAMES > 1) ? 1 : 0);
    localparam logic               CAN_TURN  = 1'(NUM_FRAMES > 1);

    logic dir;      // 0 = up, 1 = down
    logic dir_n;
`endif

    logic               tick_q;
    logic               tick_rise;
    logic [1:0]         state;
    logic [1:0]         state_n;
    logic [TPF_W-1:0]   tick_cnt;
    logic [TPF_W-1:0]   cnt_n;
    logic [FRAME_W-1:0] idx_n;
    logic               stb_n;
    logic               done_n;

    assign tick_rise = tick_clk & ~tick_q;

    always_comb begin
        state_n = state;
        cnt_n   = tick_cnt;
        idx_n   = frame_idx;
        stb_n   = 1'b0;
        done_n  = 1'b0;
`ifdef ANIM_PINGPONG_EN
        dir_n   = dir;
`endif
        if (stop) begin
            state_n = S_IDLE;
            cnt_n   = '0;
            idx_n   = '0;
        end else if (start) begin
            state_n = S_PLAY;
            cnt_n   = '0;
            idx_n   = '0;
            stb_n   = 1'b1;
`ifdef ANIM_PINGPONG_EN
            dir_n   = 1'b0;
`endif
        end else begin
            case (state)
                S_PLAY: begin
                    if (pause) begin
                        state_n = S_HOLD;
                    end else if (tick_rise) begin
                        if (tick_cnt < LAST_TICK) begin
                            cnt_n = tick_cnt + TPF_W'(1);
                        end else begin
                            cnt_n = '0;
                            // Frame advance point; loop_en is only looked at here.
                            if (!loop_en) begin
                                if (frame_idx < LAST_FRAME) begin
                                    idx_n = frame_idx + FRAME_W'(1);
                                    stb_n = 1'b1;
                                end else begin
                                    state_n = S_IDLE;
                                    done_n  = 1'b1;
                                end
`ifdef ANIM_PINGPONG_EN
                                dir_n = 1'b0;
`endif
                            end else begin
                                stb_n = 1'b1;
`ifdef ANIM_PINGPONG_EN
                                if (!dir) begin
                                    if (frame_idx < LAST_FRAME) begin
                                        idx_n = frame_idx + FRAME_W'(1);
                                    end else begin
                                        idx_n = TURN_DOWN;
                                        dir_n = CAN_TURN;
                                    end
                                end else begin
                                    if (frame_idx != '0) begin
                                        idx_n = frame_idx - FRAME_W'(1);
                                    end else begin
                                        idx_n = TURN_UP;
                                        dir_n = 1'b0;
                                    end
                                end
`else
                                idx_n = (frame_idx < LAST_FRAME) ? frame_idx + FRAME_W'(1) : '0;
`endif
                            end
                        end
                    end
                end
                S_HOLD: begin
                    // Resuming swallows any tick edge seen in the same cycle.
                    if (!pause) begin
                        state_n = S_PLAY;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge I_CLK) begin
        if (rst) begin
            tick_q    <= 1'b0;
            state     <= S_IDLE;
            tick_cnt  <= '0;
            frame_idx <= '0;
            frame_stb <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
`ifdef ANIM_PINGPONG_EN
            dir       <= 1'b0;
`endif
        end else begin
            tick_q    <= tick_clk;
            state     <= state_n;
            tick_cnt  <= cnt_n;
            frame_idx <= idx_n;
            frame_stb <= stb_n;
            done      <= done_n;
            busy      <= (state_n != S_IDLE);
`ifdef ANIM_PINGPONG_EN
            dir       <= dir_n;
`endif
        end
    end

endmodule

// File: tb/tb_anim_frame_sequencer.sv
// Testbench for anim_frame_sequencer (NUM_FRAMES=4, TICKS_PER_FRAME=2).
// Drives directed scenarios and then random stimulus. A reference model
// pushes the expected per-cycle state and the expected pulses into queues.
// A monitor on the falling clock edge pops those entries and compares them.
module tb_anim_frame_sequencer;

    localparam int NF  = 4;
    localparam int TPF = 2;
    localparam int FW  = 6;

    localparam int M_IDLE = 0;
    localparam int M_PLAY = 1;
    localparam int M_HOLD = 2;

    logic          I_CLK = 1'b0;
    logic          rst, tick_clk, start, stop, pause, loop_en;
    logic [FW-1:0] frame_idx;
    logic          frame_stb, busy, done;

    anim_frame_sequencer #(
        .NUM_FRAMES(NF),
        .FRAME_W(FW),
        .TICKS_PER_FRAME(TPF),
        .TPF_W(8)
    ) dut (
        .I_CLK(I_CLK),
        .rst(rst),
        .tick_clk(tick_clk),
        .start(start),
        .stop(stop),
        .pause(pause),
        .loop_en(loop_en),
        .frame_idx(frame_idx),
        .frame_stb(frame_stb),
        .busy(busy),
        .done(done)
    );

    always #5 I_CLK = ~I_CLK;

    typedef struct {
        int stamp;
        bit busy;
        int idx;
    } state_t;

    typedef struct {
        int stamp;
        bit is_done;
        int idx;
    } ev_t;

    state_t st_q[$];
    ev_t    ev_q[$];

    int cyc       = 0;
    int n_checks  = 0;
    int n_pass    = 0;
    int stb_seen  = 0;
    int done_seen = 0;

    // Reference model state: playback mode, ticks into the current frame,
    // shown frame, direction of travel and last seen tick level.
    int m_state = M_IDLE;
    int m_ticks = 0;
    int m_idx   = 0;
    int m_step  = 1;
    bit m_tq    = 1'b0;

    always @(posedge I_CLK) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Next frame after a completed frame in loop mode.
    function automatic int loop_next(input int idx, inout int stp);
        int nxt;
`ifdef ANIM_PINGPONG_EN
        if (NF == 1) return 0;
        nxt = idx + stp;
        if (nxt > NF - 1) begin stp = -1; nxt = NF - 2; end
        else if (nxt < 0) begin stp = 1; nxt = 1; end
        return nxt;
`else
        nxt = (idx + 1) % NF;
        return nxt;
`endif
    endfunction

    // Predict the outcome of the next clock edge from the current inputs.
    task automatic model_step();
        bit rise;
        bit stb;
        bit dn;
        stb = 0;
        dn  = 0;
        if (rst) begin
            m_state = M_IDLE; m_ticks = 0; m_idx = 0; m_step = 1; m_tq = 0;
        end else begin
            rise = tick_clk && !m_tq;
            m_tq = tick_clk;
            if (stop) begin
                m_state = M_IDLE; m_ticks = 0; m_idx = 0;
            end else if (start) begin
                m_state = M_PLAY; m_ticks = 0; m_idx = 0; m_step = 1; stb = 1;
            end else if (m_state == M_PLAY) begin
                if (pause) m_state = M_HOLD;
                else if (rise) begin
                    m_ticks++;
                    if (m_ticks == TPF) begin
                        m_ticks = 0;
                        if (!loop_en) begin
                            m_step = 1;
                            if (m_idx == NF - 1) begin m_state = M_IDLE; dn = 1; end
                            else begin m_idx++; stb = 1; end
                        end else begin
                            m_idx = loop_next(m_idx, m_step);
                            stb = 1;
                        end
                    end
                end
            end else if (m_state == M_HOLD && !pause) begin
                m_state = M_PLAY;
            end
        end
        st_q.push_back('{stamp: cyc + 1, busy: (m_state != M_IDLE), idx: m_idx});
        if (stb) ev_q.push_back('{stamp: cyc + 1, is_done: 1'b0, idx: m_idx});
        if (dn)  ev_q.push_back('{stamp: cyc + 1, is_done: 1'b1, idx: m_idx});
    endtask

    always @(negedge I_CLK) begin
        state_t s;
        ev_t    e;
        bit     has_exp;
        if (cyc > 0) begin
            if (frame_stb === 1'b1) stb_seen++;
            if (done === 1'b1) done_seen++;
            if (st_q.size() > 0 && st_q[0].stamp == cyc) begin
                s = st_q.pop_front();
                check("busy", int'(busy), int'(s.busy));
                check("frame_idx", int'(frame_idx), s.idx);
            end
            has_exp = (ev_q.size() > 0 && ev_q[0].stamp == cyc);
            if (frame_stb === 1'b1 || done === 1'b1 || has_exp) begin
                check("pulse_present", int'((frame_stb === 1'b1) || (done === 1'b1)), int'(has_exp));
                if (has_exp) begin
                    e = ev_q.pop_front();
                    check("done_pulse", int'(done === 1'b1), int'(e.is_done));
                    check("stb_pulse", int'(frame_stb === 1'b1), int'(!e.is_done));
                    check("pulse_idx", int'(frame_idx), e.idx);
                end
            end
        end
    end

    task automatic step();
        model_step();
        @(posedge I_CLK);
        #2;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic tick_edges(input int n);
        for (int i = 0; i < n; i++) begin
            tick_clk = 1'b0; step();
            tick_clk = 1'b1; step();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

    initial begin
        int s0;
        int d0;
        rst = 1'b1; tick_clk = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; loop_en = 1'b0;
        #2;
        step(); step();
        check("reset_idx", int'(frame_idx), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_stb", int'(frame_stb), 0);
        check("reset_done", int'(done), 0);
        rst = 1'b0;
        step();

        // Play once
        s0 = stb_seen; d0 = done_seen;
        loop_en = 1'b0; start = 1'b1; step();
        tick_edges(8);
        step(); step();
        check("once_stb_count", stb_seen - s0, 4);
        check("once_done_count", done_seen - d0, 1);
        check("once_final_idx", int'(frame_idx), 3);
        check("once_busy", int'(busy), 0);

        // Loop: five advances end on frame 1 both when wrapping and in ping-pong
        d0 = done_seen;
        loop_en = 1'b1; start = 1'b1; step();
        tick_edges(10);
        step();
        check("loop_final_idx", int'(frame_idx), 1);
        check("loop_no_done", done_seen - d0, 0);

        // Pause
        start = 1'b1; step();
        tick_edges(3);
        pause = 1'b1; step();
        tick_edges(3);
        check("pause_idx", int'(frame_idx), 1);
        check("pause_busy", int'(busy), 1);
        pause = 1'b0; step();
        tick_edges(1);
        check("resume_idx", int'(frame_idx), 2);

        // Stop, then start and stop together
        d0 = done_seen;
        stop = 1'b1; step();
        check("stop_idx", int'(frame_idx), 0);
        check("stop_busy", int'(busy), 0);
        start = 1'b1; stop = 1'b1; step();
        check("startstop_busy", int'(busy), 0);
        step();
        check("stop_no_done", done_seen - d0, 0);

        // Restart mid-play in frame 3 with one tick counted
        start = 1'b1; step();
        tick_edges(7);
        check("pre_restart_idx", int'(frame_idx), 3);
        start = 1'b1; step();
        check("restart_idx", int'(frame_idx), 0);
        check("restart_stb", int'(frame_stb), 1);
        tick_edges(1);
        check("restart_hold_idx", int'(frame_idx), 0);
        tick_edges(1);
        check("restart_adv_idx", int'(frame_idx), 1);

        // Reset mid-play with tick_clk high
        tick_clk = 1'b1;
        rst = 1'b1; step();
        check("rst_mid_idx", int'(frame_idx), 0);
        check("rst_mid_busy", int'(busy), 0);
        rst = 1'b0; step(); step();
        check("no_phantom_idx", int'(frame_idx), 0);
        check("no_phantom_busy", int'(busy), 0);

        // Random stimulus
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 999) < 3);
            start    = ($urandom_range(0, 99) < 3);
            stop     = ($urandom_range(0, 99) < 1);
            if ($urandom_range(0, 99) < 5) pause = ~pause;
            if ($urandom_range(0, 99) < 2) loop_en = ~loop_en;
            tick_clk = 1'($urandom_range(0, 1));
            step();
        end
        rst = 1'b0;
        step(); step(); step();
        check("events_drained", ev_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/anim_frame_sequencer.md
# anim_frame_sequencer

Animation frame sequencer that consumes the divided clock produced by the clock divider stage and steps a frame index through an animation sequence. Each rising edge of the divided clock is one animation tick, and a programmable number of ticks makes up one frame. Start, stop, pause and loop are controlled by the projector control logic. The frame index drives the frame-memory address generator downstream.

## Interface
- `NUM_FRAMES`, default 48: frames in the sequence, 1..2^FRAME_W.
- `FRAME_W`, default 6: width of the frame index.
- `TICKS_PER_FRAME`, default 5: divided-clock rising edges per frame, ≥1.
- `TPF_W`, default 8: width of the internal tick counter; must hold TICKS_PER_FRAME-1.

Ports:
- `I_CLK`  in  1  system clock.
- `rst`  in  1  reset: synchronous, active-high; clock I_CLK.
- `tick_clk`  in  1  divided clock from the divider. It is a register output in the I_CLK domain, so no synchronizer is used.
- `start`  in  1  single-cycle pulse: (re)start the sequence at frame 0.
- `stop`  in  1  single-cycle pulse: abort and return to idle.
- `pause`  in  1  level: freeze the sequence while high.
- `loop_en`  in  1  level: 1 = repeat forever, 0 = play once.
- `frame_idx`  out  FRAME_W  current frame.
- `frame_stb`  out  1  one-cycle pulse whenever a new frame is presented.
- `busy`  out  1  high in PLAY or HOLD.
- `done`  out  1  one-cycle pulse when a play-once sequence completes.

## Operation
- Tick detection:
  - `tick_q` registers `tick_clk` (reset 0).
  - `tick_rise = tick_clk & ~tick_q`.
- States:
  - IDLE: not playing.
  - PLAY: counting ticks and advancing frames.
  - HOLD: paused.
- Priority per cycle, highest first: rst > stop > start > pause > tick_rise.
- Transitions:
  - rst: IDLE. All outputs, `tick_cnt` and `dir` go to 0.
  - stop (any state): IDLE, `frame_idx`<=0, `tick_cnt`<=0. No `done`, no `frame_stb`.
  - start (any state): PLAY, `frame_idx`<=0, `tick_cnt`<=0, `dir`<=up, `frame_stb`<=1.
  - PLAY with pause=1: HOLD. `tick_rise` is ignored and `tick_cnt` is retained.
  - HOLD with pause=0: PLAY. A `tick_rise` in the same cycle is ignored.
  - pause in IDLE has no effect.
- Counting in PLAY, on `tick_rise`:
  - If `tick_cnt`<TICKS_PER_FRAME-1, increment `tick_cnt`.
  - Otherwise `tick_cnt`<=0 and the frame advances.
- Frame advance, forward direction:
  - If `frame_idx`<NUM_FRAMES-1: `frame_idx`+1, `frame_stb`<=1.
  - At last frame with loop_en=1: `frame_idx`<=0, `frame_stb`<=1 (wrap).
  - At last frame with loop_en=0: IDLE, `done`<=1, `frame_idx` holds NUM_FRAMES-1, no `frame_stb`.
- `loop_en` is sampled only at the advance point. Changing it mid-sequence affects the next end-of-sequence decision only.
- NUM_FRAMES=1: `frame_idx` stays 0.
  - Loop: `frame_stb` pulses every TICKS_PER_FRAME ticks.
  - Once: `done` after TICKS_PER_FRAME ticks.
- `busy` is 1 exactly when the state is PLAY or HOLD.

## Timing
- All outputs are registered. Reset values: `frame_idx`=0, `frame_stb`=0, `busy`=0, `done`=0.
- start sampled at edge k: PLAY, `busy`=1, `frame_stb`=1 during cycle k+1.
- Frame advance: `frame_idx` updates at the I_CLK edge where `tick_clk`=1 and `tick_q`=0 are sampled. `frame_stb` is high for the following cycle only.
- `done` and `busy`=0 appear at the same edge as the final advance point.
- `frame_stb` and `done` are never high in the same cycle.

## Configuration
- Macro: `ANIM_PINGPONG_EN`.
- Defined, with loop_en=1: ping-pong playback.
  - An up/down `dir` register is added.
  - Going up, at NUM_FRAMES-1 `dir` flips and the next advance goes to NUM_FRAMES-2.
  - Going down, at 0 `dir` flips and the next advance goes to 1.
  - Every step pulses `frame_stb`.
  - With NUM_FRAMES=1 the index stays 0.
- Defined, with loop_en=0: behaves as without the macro, always forward.
- Not defined: the `dir` logic is absent and loop mode wraps NUM_FRAMES-1 → 0.

## Test plan
All scenarios use NUM_FRAMES=4 and TICKS_PER_FRAME=2.
- Play once:
  - Stimulus: start, loop_en=0, 8 tick_clk rising edges.
  - Required: `frame_idx` 0,1,2,3 with 4 `frame_stb` pulses (including the start pulse).
  - Required: on the 8th edge, `done` pulses once, `busy`=0, `frame_idx` holds 3.
- Loop wrap:
  - Stimulus: loop_en=1, 10 rising edges after start.
  - Required: `frame_idx` sequence 0,1,2,3,0,1 and no `done`.
  - With `ANIM_PINGPONG_EN` defined, required sequence is 0,1,2,3,2,1.
- Pause:
  - Stimulus: after 1 tick in frame 1, assert pause across 3 rising edges, then release.
  - Required: `frame_idx` stays 1, `busy`=1.
  - Required: the first edge after release advances to frame 2.
- Stop and restart:
  - Stimulus: stop during frame 2.
  - Required: next cycle `frame_idx`=0, `busy`=0, no `done`.
  - Stimulus: start and stop asserted in the same cycle.
  - Required: IDLE.
- Restart mid-play:
  - Stimulus: start pulse while in frame 3 with `tick_cnt`=1.
  - Required: `frame_idx`=0, `frame_stb` pulse, and the next advance occurs only after 2 new edges.
- Reset mid-operation:
  - Stimulus: rst in PLAY while `tick_clk`=1.
  - Required: all outputs 0 the next cycle.
  - Required: no phantom advance after reset deasserts while `tick_clk` stays high.
